// File: rtl/wb_hls_ctl_slave.sv
// ============================================================================
// Module   : wb_hls_ctl_slave
// Brief    : WISHBONE register slave that launches an ap_ctrl_hs HLS core and
//            captures its result. Optional interrupt: WB_HLS_CTL_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_hls_ctl_slave #(
    parameter int          WB_ADR_WIDTH = 8,
    parameter int          WB_DAT_WIDTH = 64,
    parameter int          WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [63:0] CORE_ID      = 64'h527a_0000_0000_0001
) (
    input  logic                    s_wb_clk_i,
    input  logic                    s_wb_rst_i,
    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic                    s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,
    output logic                    ap_start,
    input  logic                    ap_ready,
    input  logic                    ap_done,
    input  logic                    ap_idle,
    output logic [DATA_WIDTH-1:0]   ap_a,
    output logic [DATA_WIDTH-1:0]   ap_b,
    input  logic [DATA_WIDTH-1:0]   ap_return,
    output logic                    irq
);

    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_CORE_ID = WB_ADR_WIDTH'(0);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_CONTROL = WB_ADR_WIDTH'(4);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_STATUS  = WB_ADR_WIDTH'(5);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_IRQ_EN  = WB_ADR_WIDTH'(6);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_A       = WB_ADR_WIDTH'(8);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_B       = WB_ADR_WIDTH'(9);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_C       = WB_ADR_WIDTH'(10);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_ack;
    logic [WB_DAT_WIDTH-1:0] r_dat;
    logic                    r_start;
    logic                    r_done;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_c;

    logic                    w_acc;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_busy;
    logic                    w_start_req;
    logic [WB_DAT_WIDTH-1:0] w_rdata;
    logic [WB_DAT_WIDTH-1:0] w_irqen_rd;
    logic                    w_unused;

    // An access is the single cycle where stb is seen and ack is not yet out.
    assign w_acc       = s_wb_stb_i & ~r_ack;
    assign w_wr        = w_acc & s_wb_we_i;
    assign w_rd        = w_acc & ~s_wb_we_i;
    assign w_busy      = (r_state != S_IDLE);
    assign w_start_req = w_wr & (s_wb_adr_i == c_ADR_CONTROL) & s_wb_sel_i[0] & s_wb_dat_i[0];
    assign w_unused    = &{1'b0, s_wb_dat_i, s_wb_sel_i};

    assign s_wb_ack_o = r_ack;
    assign s_wb_dat_o = r_dat;
    assign ap_start   = r_start;
    assign ap_a       = r_a;
    assign ap_b       = r_b;

    always_comb begin
        w_rdata = '0;
        case (s_wb_adr_i)
            c_ADR_CORE_ID: w_rdata = WB_DAT_WIDTH'(CORE_ID);
            c_ADR_CONTROL: w_rdata = WB_DAT_WIDTH'(r_start);
            c_ADR_STATUS:  w_rdata = WB_DAT_WIDTH'({ap_idle, r_done, w_busy});
            c_ADR_IRQ_EN:  w_rdata = w_irqen_rd;
            c_ADR_A:       w_rdata = WB_DAT_WIDTH'(r_a);
            c_ADR_B:       w_rdata = WB_DAT_WIDTH'(r_b);
            c_ADR_C:       w_rdata = WB_DAT_WIDTH'(r_c);
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge s_wb_clk_i) begin
        if (s_wb_rst_i) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_dat <= w_rdata;
            end

            // Arguments are frozen while the core owns them.
            if (w_wr && !w_busy) begin
                for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                    if (s_wb_sel_i[i] && s_wb_adr_i == c_ADR_A) r_a[i*8 +: 8] <= s_wb_dat_i[i*8 +: 8];
                    if (s_wb_sel_i[i] && s_wb_adr_i == c_ADR_B) r_b[i*8 +: 8] <= s_wb_dat_i[i*8 +: 8];
                end
            end

            // Read-to-clear first; a completion below overrides it in the same cycle.
            if (w_rd && s_wb_adr_i == c_ADR_STATUS) begin
                r_done <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_req) begin
                        r_start <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (ap_ready) begin
                        r_start <= 1'b0;
                        if (ap_done) begin
                            r_c     <= ap_return;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (ap_done) begin
                        r_c     <= ap_return;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef WB_HLS_CTL_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    assign w_irqen_rd = WB_DAT_WIDTH'(r_irq_en);
    assign irq        = r_irq;

    always_ff @(posedge s_wb_clk_i) begin
        if (s_wb_rst_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && s_wb_adr_i == c_ADR_IRQ_EN && s_wb_sel_i[0]) begin
                r_irq_en <= s_wb_dat_i[0];
            end
            r_irq <= r_irq_en & r_done;
        end
    end
`else
    assign w_irqen_rd = '0;
    assign irq        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_hls_ctl_slave.sv
// ============================================================================
// Module   : tb_wb_hls_ctl_slave
// Brief    : Self-checking bench for wb_hls_ctl_slave against a transaction-
//            level model of the register map and job sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_hls_ctl_slave;

    localparam logic [63:0] c_CORE_ID = 64'h527a_0000_0000_0001;
`ifdef WB_HLS_CTL_IRQ_EN
    localparam bit c_IRQ = 1'b1;
`else
    localparam bit c_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  adr = '0;
    logic [63:0] dat_i = '0;
    logic [63:0] dat_o;
    logic        we = 1'b0;
    logic [7:0]  sel = '0;
    logic        stb = 1'b0;
    logic        ack;
    logic        ap_start;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_idle = 1'b1;
    logic [31:0] ap_a;
    logic [31:0] ap_b;
    logic [31:0] ap_return = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_a = '0, m_b = '0, m_c = '0;
    bit          m_done = 0, m_busy = 0, m_start = 0, m_irq_en = 0;

    wb_hls_ctl_slave dut (
        .s_wb_clk_i (clk),
        .s_wb_rst_i (rst),
        .s_wb_adr_i (adr),
        .s_wb_dat_i (dat_i),
        .s_wb_dat_o (dat_o),
        .s_wb_we_i  (we),
        .s_wb_sel_i (sel),
        .s_wb_stb_i (stb),
        .s_wb_ack_o (ack),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_a       (ap_a),
        .ap_b       (ap_b),
        .ap_return  (ap_return),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++)
            if (s[i]) mask = mask | (64'hFF << (8 * i));
        return 32'((64'(old) & ~mask) | (d & mask));
    endfunction

    function automatic logic [63:0] exp_read(input logic [7:0] a);
        case (a)
            8'd0:    return c_CORE_ID;
            8'd4:    return 64'(m_start);
            8'd5:    return 64'({ap_idle, m_done, m_busy});
            8'd6:    return 64'(m_irq_en);
            8'd8:    return 64'(m_a);
            8'd9:    return 64'(m_b);
            8'd10:   return 64'(m_c);
            default: return 64'h0;
        endcase
    endfunction

    task automatic wb_access(input logic w, input logic [7:0] a, input logic [63:0] d,
                             input logic [7:0] s, output logic [63:0] rd);
        int n;
        stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < 4);
        check("wb_ack", 64'(ack), 64'h1);
        rd = dat_o;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] unused_rd;
        case (a)
            8'd4: if (s[0] && d[0] && !m_busy) begin m_busy = 1; m_start = 1; m_done = 0; end
            8'd6: if (c_IRQ && s[0]) m_irq_en = d[0];
            8'd8: if (!m_busy) m_a = merge(m_a, d, s);
            8'd9: if (!m_busy) m_b = merge(m_b, d, s);
            default: ;
        endcase
        wb_access(1'b1, a, d, s, unused_rd);
    endtask

    task automatic rd_chk(input logic [7:0] a, input string tag);
        logic [63:0] exp, got;
        exp = exp_read(a);
        wb_access(1'b0, a, 64'h0, 8'hFF, got);
        check(tag, got, exp);
        if (a == 8'd5) m_done = 0;
    endtask

    task automatic finish_job(input logic [31:0] ret);
        m_c = ret; m_done = 1; m_busy = 0; m_start = 0;
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ret,
                           input int r_lat, input int d_lat);
        wr(8'd8, 64'(a), 8'hFF);
        wr(8'd9, 64'(b), 8'hFF);
        wr(8'd4, 64'h1, 8'h01);
        ap_idle = 1'b0;
        check("start_rise", 64'(ap_start), 64'h1);
        check("arg_a", 64'(ap_a), 64'(m_a));
        check("arg_b", 64'(ap_b), 64'(m_b));
        for (int i = 0; i < r_lat; i++) begin
            tick();
            check("start_hold", 64'(ap_start), 64'h1);
        end
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        m_start = 0;
        check("start_fall", 64'(ap_start), 64'h0);
        wr(8'd4, 64'h1, 8'hFF);
        wr(8'd8, 64'h5, 8'hFF);
        check("no_restart", 64'(ap_start), 64'h0);
        check("a_frozen", 64'(ap_a), 64'(m_a));
        rd_chk(8'd5, "status_busy");
        for (int i = 0; i < d_lat; i++) tick();
        ap_done = 1'b1; ap_return = ret;
        tick();
        ap_done = 1'b0; ap_return = $urandom;
        finish_job(ret);
        ap_idle = 1'b1;
        check("irq_lag", 64'(irq), 64'h0);
        tick();
        check("irq_rise", 64'(irq), 64'(m_irq_en));
        rd_chk(8'd10, "c_capture");
        rd_chk(8'd5, "status_done");
        check("irq_hold", 64'(irq), 64'(m_irq_en));
        tick();
        check("irq_clear", 64'(irq), 64'h0);
        rd_chk(8'd5, "status_clr");
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] exp;
        logic [31:0] r;

        repeat (2) tick();
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_dat", dat_o, 64'h0);
        check("rst_start", 64'(ap_start), 64'h0);
        check("rst_a", 64'(ap_a), 64'h0);
        check("rst_b", 64'(ap_b), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        rst = 1'b0;
        tick();

        rd_chk(8'd0, "core_id");
        rd_chk(8'd5, "status_reset");
        check("status_reset_val", exp_read(8'd5), 64'h4);

        // Byte enables and truncation above the argument width
        wr(8'd8, 64'h0, 8'hFF);
        wr(8'd8, 64'h1122_3344, 8'h01);
        rd_chk(8'd8, "a_sel01");
        wr(8'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rd_chk(8'd9, "b_trunc");
        for (int i = 0; i < 6; i++) begin
            wr(8'(8 + (i % 2)), {$urandom, $urandom}, 8'($urandom));
            rd_chk(8'(8 + (i % 2)), "ab_rand_sel");
        end

        // Unmapped space
        wr(8'd3, 64'hDEAD, 8'hFF);
        rd_chk(8'd3, "unmapped_3");
        rd_chk(8'd255, "unmapped_255");

        // IRQ enable register
        wr(8'd6, 64'h1, 8'h01);
        rd_chk(8'd6, "irq_en_reg");

        run_job(32'd7777, 32'd1111, 32'd8888, 2, 5);

        for (int j = 0; j < 4; j++)
            run_job($urandom, $urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));

        // Completion pulse while idle must not be captured
        ap_done = 1'b1; ap_return = 32'hA5A5_5A5A;
        tick();
        ap_done = 1'b0;
        rd_chk(8'd10, "done_idle_c");
        rd_chk(8'd5, "done_idle_status");

        // STATUS read colliding with ap_done: set wins, read sees old value
        wr(8'd4, 64'h1, 8'h01);
        ap_idle = 1'b0;
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        m_start = 0;
        tick();
        r = $urandom;
        exp = exp_read(8'd5);
        stb = 1'b1; we = 1'b0; adr = 8'd5; sel = 8'hFF;
        ap_done = 1'b1; ap_return = r;
        tick();
        ap_done = 1'b0;
        check("collide_ack", 64'(ack), 64'h1);
        check("collide_status", dat_o, exp);
        stb = 1'b0;
        finish_job(r);
        ap_idle = 1'b1;
        rd_chk(8'd5, "collide_done_kept");
        rd_chk(8'd5, "collide_done_clr");
        rd_chk(8'd10, "collide_c");

        // Zero-latency core
        r = $urandom;
        wr(8'd4, 64'h1, 8'h01);
        ap_ready = 1'b1; ap_done = 1'b1; ap_return = r;
        tick();
        ap_ready = 1'b0; ap_done = 1'b0;
        finish_job(r);
        check("zl_start", 64'(ap_start), 64'h0);
        rd_chk(8'd5, "zl_status");
        rd_chk(8'd10, "zl_c");

        // Reset with a job outstanding
        wr(8'd4, 64'h1, 8'h01);
        rd_chk(8'd4, "ctrl_readback");
        check("pre_rst_start", 64'(ap_start), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_a = '0; m_b = '0; m_c = '0; m_done = 0; m_busy = 0; m_start = 0; m_irq_en = 0;
        check("rst_mid_start", 64'(ap_start), 64'h0);
        check("rst_mid_irq", 64'(irq), 64'h0);
        rd_chk(8'd5, "rst_mid_status");
        rd_chk(8'd10, "rst_mid_c");
        rd_chk(8'd8, "rst_mid_a");
        rd_chk(8'd6, "rst_mid_irqen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
